// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer.
// Takes the decoded mode/baud fields and a TX byte from the register block,
// then runs one frame: SS_n low, a lead-in half period, 2*DATA_WIDTH SCK
// edges spaced one half period apart, a trailing half period, and a one-cycle
// DONE state that raises done_out/spif_out and publishes the received byte.
// start_in while a frame is in flight raises the sticky write-collision flag.
// Dropping spe_in mid-frame aborts back to idle with no completion.
module spi_xfer_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 11
) (
  input  logic                  apb_clk_in,
  input  logic                  apb_rst_in,
  input  logic                  spe_in,
  input  logic                  cpol_in,
  input  logic                  cpha_in,
  input  logic                  lsbfe_in,
  input  logic [2:0]            sppr_in,
  input  logic [2:0]            spr_in,
  input  logic                  start_in,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  clr_flags_in,
  input  logic                  miso_in,
  output logic                  sck_out,
  output logic                  mosi_out,
  output logic                  ss_n_out,
  output logic                  busy_out,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  done_out,
  output logic                  spif_out,
  output logic                  wcol_out
);

  // One SCK edge per half period; a frame has two edges per bit.
  localparam int EDGES  = 2 * DATA_WIDTH;
  localparam int EDGE_W = $clog2(EDGES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_DONE
  } state_t;

  state_t                state;
  logic [DIV_WIDTH-1:0]  div_cnt;       // cycles elapsed in the current half period
  logic [DIV_WIDTH-1:0]  half_last_q;   // H-1, frozen at frame start
  logic [EDGE_W-1:0]     edge_cnt;      // SCK edges already produced this frame
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  lsbfe_q;
  logic                  sck_q;
  logic                  mosi_q;
  logic                  ss_n_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  spif_q;
  logic                  wcol_q;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] rx_data_q;

  // Baud decode: H = (sppr+1) << spr, kept as H-1 so the divider compares directly.
  logic [DIV_WIDTH-1:0] half_cycles;
  logic [DIV_WIDTH-1:0] half_last;
  assign half_cycles = (DIV_WIDTH'({1'b0, sppr_in}) + DIV_WIDTH'(1)) << spr_in;
  assign half_last   = half_cycles - DIV_WIDTH'(1);

  // First bit on the wire and the shift register left behind once it is sent.
  logic                  start_bit;
  logic [DATA_WIDTH-1:0] start_rest;
  assign start_bit  = lsbfe_in ? tx_data_in[0] : tx_data_in[DATA_WIDTH-1];
  assign start_rest = lsbfe_in ? (tx_data_in >> 1) : (tx_data_in << 1);

  // Next bit to transmit and the matching shifted register, in the latched bit order.
  logic                  tx_bit;
  logic [DATA_WIDTH-1:0] tx_rest;
  logic [DATA_WIDTH-1:0] rx_next;
  assign tx_bit  = lsbfe_q ? tx_sr[0] : tx_sr[DATA_WIDTH-1];
  assign tx_rest = lsbfe_q ? (tx_sr >> 1) : (tx_sr << 1);
  assign rx_next = lsbfe_q ? {miso_in, rx_sr[DATA_WIDTH-1:1]}
                           : {rx_sr[DATA_WIDTH-2:0], miso_in};

  // Edge scheduling. Odd edge numbers are leading, even ones trailing.
  // With CPHA=0 the first bit goes out on LEAD entry, so only trailing
  // edges 2..EDGES-2 drive; with CPHA=1 every leading edge drives.
  logic              div_hit;
  logic [EDGE_W-1:0] next_edge;
  logic              lead_edge;
  logic              edge_fire;
  logic              do_sample;
  logic              do_drive;
  assign div_hit   = (div_cnt == half_last_q);
  assign next_edge = edge_cnt + EDGE_W'(1);
  assign lead_edge = next_edge[0];
  assign edge_fire = spe_in && div_hit &&
                     ((state == ST_LEAD) ||
                      ((state == ST_SHIFT) && (edge_cnt != EDGE_W'(EDGES))));
  assign do_sample = edge_fire && (lead_edge ^ cpha_q);
  assign do_drive  = edge_fire &&
                     (cpha_q ? lead_edge
                             : (!lead_edge && (next_edge <= EDGE_W'(EDGES - 2))));

  // Frame sequencer: state, divider, SCK/MOSI generation, flags and result byte.
  // NOTE: every register here is assigned with <= so all updates in a clock
  // edge see the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      state       <= ST_IDLE;
      div_cnt     <= '0;
      half_last_q <= '0;
      edge_cnt    <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsbfe_q     <= 1'b0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      ss_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      spif_q      <= 1'b0;
      wcol_q      <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rx_data_q   <= '0;
    end else begin
      done_q <= 1'b0;

      // NOTE: the clear is written before any set below; with non-blocking
      // assignments the later statement wins, so a set in the same cycle
      // takes priority over clr_flags_in.
      if (clr_flags_in) begin
        spif_q <= 1'b0;
        wcol_q <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (start_in && spe_in) begin
            state       <= ST_LEAD;
            busy_q      <= 1'b1;
            ss_n_q      <= 1'b0;
            div_cnt     <= '0;
            edge_cnt    <= '0;
            half_last_q <= half_last;
            cpol_q      <= cpol_in;
            cpha_q      <= cpha_in;
            lsbfe_q     <= lsbfe_in;
            sck_q       <= cpol_in;
            rx_sr       <= '0;
            if (!cpha_in) begin
              mosi_q <= start_bit;
              tx_sr  <= start_rest;
            end else begin
              tx_sr  <= tx_data_in;
            end
          end
        end

        default: begin
          if (!spe_in) begin
            // Abort: drop the frame silently, leave rx_data_out and flags alone.
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            ss_n_q   <= 1'b1;
            sck_q    <= cpol_q;
            div_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            if (start_in) begin
              wcol_q <= 1'b1;
            end

            case (state)
              ST_LEAD: begin
                if (div_hit) begin
                  state   <= ST_SHIFT;
                  div_cnt <= '0;
                end else begin
                  div_cnt <= div_cnt + DIV_WIDTH'(1);
                end
              end

              ST_SHIFT: begin
                if (div_hit) begin
                  div_cnt <= '0;
                  if (edge_cnt == EDGE_W'(EDGES)) begin
                    state <= ST_TRAIL;
                  end
                end else begin
                  div_cnt <= div_cnt + DIV_WIDTH'(1);
                end
              end

              ST_TRAIL: begin
                if (div_hit) begin
                  state     <= ST_DONE;
                  div_cnt   <= '0;
                  edge_cnt  <= '0;
                  ss_n_q    <= 1'b1;
                  done_q    <= 1'b1;
                  spif_q    <= 1'b1;
                  rx_data_q <= rx_sr;
                end else begin
                  div_cnt <= div_cnt + DIV_WIDTH'(1);
                end
              end

              ST_DONE: begin
                state  <= ST_IDLE;
                busy_q <= 1'b0;
              end

              default: begin
                state <= ST_IDLE;
              end
            endcase
          end
        end
      endcase

      // SCK edge actions, shared by the LEAD->SHIFT transition and SHIFT itself.
      if (edge_fire) begin
        sck_q    <= ~sck_q;
        edge_cnt <= next_edge;
        if (do_sample) begin
          rx_sr <= rx_next;
        end
        if (do_drive) begin
          mosi_q <= tx_bit;
          tx_sr  <= tx_rest;
        end
      end
    end
  end

  // While idle, SCK follows the live CPOL field so the bus idles at the right level.
  assign sck_out     = busy_q ? sck_q : cpol_in;
  assign mosi_out    = mosi_q;
  assign ss_n_out    = ss_n_q;
  assign busy_out    = busy_q;
  assign rx_data_out = rx_data_q;
  assign done_out    = done_q;
  assign spif_out    = spif_q;
  assign wcol_out    = wcol_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl: a table of complete frames in several
// modes and baud settings, plus hand sequences for collision, flag-clear
// priority, disabled start, mid-frame abort and mid-frame reset.
module tb_spi_xfer_ctrl;

  logic       apb_clk_in = 1'b0;
  logic       apb_rst_in;
  logic       spe_in;
  logic       cpol_in;
  logic       cpha_in;
  logic       lsbfe_in;
  logic [2:0] sppr_in;
  logic [2:0] spr_in;
  logic       start_in;
  logic [7:0] tx_data_in;
  logic       clr_flags_in;
  logic       miso_in;
  logic       sck_out;
  logic       mosi_out;
  logic       ss_n_out;
  logic       busy_out;
  logic [7:0] rx_data_out;
  logic       done_out;
  logic       spif_out;
  logic       wcol_out;

  spi_xfer_ctrl dut (
    .apb_clk_in   (apb_clk_in),
    .apb_rst_in   (apb_rst_in),
    .spe_in       (spe_in),
    .cpol_in      (cpol_in),
    .cpha_in      (cpha_in),
    .lsbfe_in     (lsbfe_in),
    .sppr_in      (sppr_in),
    .spr_in       (spr_in),
    .start_in     (start_in),
    .tx_data_in   (tx_data_in),
    .clr_flags_in (clr_flags_in),
    .miso_in      (miso_in),
    .sck_out      (sck_out),
    .mosi_out     (mosi_out),
    .ss_n_out     (ss_n_out),
    .busy_out     (busy_out),
    .rx_data_out  (rx_data_out),
    .done_out     (done_out),
    .spif_out     (spif_out),
    .wcol_out     (wcol_out)
  );

  always #5 apb_clk_in = ~apb_clk_in;

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lsbfe;
    logic [2:0] sppr;
    logic [2:0] spr;
    logic [7:0] tx;
    logic       loop;      // 1: MISO tied to MOSI, 0: slave model drives MISO
    logic [7:0] slave;     // byte the slave model shifts out, MSB first
    logic [7:0] exp_rx;
    int         exp_done;  // cycles from acceptance edge to done_out (18*H)
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  // Stimulus-side MISO sources: loopback or a CPHA=1 slave that drives on leading edges.
  logic       loop_en = 1'b1;
  logic [7:0] slave_byte = 8'h00;
  int         slave_cnt = 0;
  logic       slave_bit;

  always @(sck_out or ss_n_out) begin
    if (ss_n_out) slave_cnt = 0;
    else if (sck_out != cpol_in) slave_cnt = slave_cnt + 1;
  end

  always_comb begin
    slave_bit = 1'b0;
    if (slave_cnt >= 1 && slave_cnt <= 8) slave_bit = slave_byte[3'(8 - slave_cnt)];
  end

  always_comb miso_in = loop_en ? mosi_out : slave_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] bitrev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

  task automatic clear_flags();
    @(negedge apb_clk_in);
    clr_flags_in = 1'b1;
    @(negedge apb_clk_in);
    clr_flags_in = 1'b0;
    check("clr_spif", spif_out, 0);
    check("clr_wcol", wcol_out, 0);
  endtask

  // Drive one frame and watch it cycle by cycle. wcol_at/clr_at (-1 = none)
  // pulse start_in/clr_flags_in during that cycle index, cycle 0 being the
  // first cycle after the acceptance edge.
  task automatic run_frame(input vec_t v, input int wcol_at, input int clr_at,
                           input logic exp_wcol);
    int h, done_cyc, dones, rises, falls, bad_gap, bad_mosi, bad_ss, last_edge;
    logic prev_sck, prev_mosi, lead_t, allowed, busy_after;
    logic [7:0] mosi_cap;
    h = (int'(v.sppr) + 1) << v.spr;
    done_cyc = -1; dones = 0; rises = 0; falls = 0;
    bad_gap = 0; bad_mosi = 0; bad_ss = 0; last_edge = 0;
    mosi_cap = 8'h00; busy_after = 1'bx;

    @(negedge apb_clk_in);
    cpol_in = v.cpol; cpha_in = v.cpha; lsbfe_in = v.lsbfe;
    sppr_in = v.sppr; spr_in = v.spr; tx_data_in = v.tx;
    loop_en = v.loop; slave_byte = v.slave;
    start_in = 1'b1;
    prev_sck = v.cpol;
    prev_mosi = mosi_out;

    for (int cyc = 0; cyc < 18 * h + 20; cyc++) begin
      @(negedge apb_clk_in);
      if (done_out) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc < 0 && (ss_n_out !== 1'b0 || busy_out !== 1'b1)) bad_ss++;
      if (sck_out !== prev_sck) begin
        if (cyc - last_edge != h) bad_gap++;
        last_edge = cyc;
        lead_t = (prev_sck == v.cpol);
        if (sck_out) rises++; else falls++;
        if (lead_t != v.cpha) mosi_cap = {mosi_cap[6:0], mosi_out};
      end
      if (mosi_out !== prev_mosi) begin
        allowed = (cyc == 0 && !v.cpha) ||
                  (sck_out !== prev_sck && ((prev_sck == v.cpol) == v.cpha));
        if (!allowed) bad_mosi++;
      end
      prev_sck = sck_out;
      prev_mosi = mosi_out;
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        busy_after = busy_out;
        break;
      end
      start_in = (cyc == wcol_at);
      if (cyc == wcol_at) tx_data_in = ~v.tx;
      clr_flags_in = (cyc == clr_at);
    end
    start_in = 1'b0;
    clr_flags_in = 1'b0;

    check("done_cycle", done_cyc, v.exp_done);
    check("done_pulses", dones, 1);
    check("rx_data", rx_data_out, v.exp_rx);
    check("spif", spif_out, 1);
    check("wcol", wcol_out, exp_wcol);
    check("sck_rises", rises, 8);
    check("sck_falls", falls, 8);
    check("sck_spacing", bad_gap, 0);
    check("mosi_timing", bad_mosi, 0);
    check("mosi_bits", mosi_cap, v.lsbfe ? bitrev(v.tx) : v.tx);
    check("ss_busy_frame", bad_ss, 0);
    check("busy_after", busy_after, 0);
    check("ss_n_after", ss_n_out, 1);
    check("sck_idle", sck_out, v.cpol);
  endtask

  task automatic start_only(input vec_t v);
    @(negedge apb_clk_in);
    cpol_in = v.cpol; cpha_in = v.cpha; lsbfe_in = v.lsbfe;
    sppr_in = v.sppr; spr_in = v.spr; tx_data_in = v.tx;
    loop_en = v.loop; slave_byte = v.slave;
    start_in = 1'b1;
    @(negedge apb_clk_in);
    start_in = 1'b0;
  endtask

  vec_t vecs[8];
  vec_t hv;
  int   dcount;

  initial begin
    //          cpol  cpha  lsbfe sppr  spr   tx     loop  slave  exp_rx exp_done
    vecs[0] = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'hA5, 1'b1, 8'h00, 8'hA5, 18};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 3'd1, 3'd1, 8'h3C, 1'b0, 8'hC3, 8'hC3, 72};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 8'h01, 1'b1, 8'h00, 8'h01, 18};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 8'h5A, 1'b1, 8'h00, 8'h5A, 54};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 3'd0, 3'd2, 8'h96, 1'b1, 8'h00, 8'h96, 72};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 3'd1, 3'd0, 8'hFF, 1'b0, 8'h81, 8'h81, 36};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 3'd7, 3'd0, 8'h3A, 1'b0, 8'h80, 8'h01, 144};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 3'd7, 3'd7, 8'hE7, 1'b1, 8'h00, 8'hE7, 18432};

    apb_rst_in = 1'b1; spe_in = 1'b1; cpol_in = 1'b0; cpha_in = 1'b0;
    lsbfe_in = 1'b0; sppr_in = 3'd0; spr_in = 3'd0; start_in = 1'b0;
    tx_data_in = 8'h00; clr_flags_in = 1'b0;

    // Reset values, and SCK tracking CPOL combinationally while idle.
    repeat (3) @(negedge apb_clk_in);
    check("rst_sck", sck_out, 0);
    check("rst_mosi", mosi_out, 0);
    check("rst_ss_n", ss_n_out, 1);
    check("rst_busy", busy_out, 0);
    check("rst_rx", rx_data_out, 0);
    check("rst_done", done_out, 0);
    check("rst_spif", spif_out, 0);
    check("rst_wcol", wcol_out, 0);
    cpol_in = 1'b1;
    #1;
    check("rst_sck_cpol1", sck_out, 1);
    cpol_in = 1'b0;
    @(negedge apb_clk_in);
    apb_rst_in = 1'b0;

    // Table of complete frames.
    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], -1, -1, 1'b0);
      clear_flags();
    end

    // Collision: second start during the frame sets WCOL but leaves data intact.
    hv = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h5A, 1'b1, 8'h00, 8'h5A, 18};
    run_frame(hv, 4, -1, 1'b1);
    clear_flags();

    // Clear requested in the same cycle SPIF gets set: the set must win.
    hv = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h33, 1'b1, 8'h00, 8'h33, 18};
    run_frame(hv, -1, 17, 1'b0);
    clear_flags();

    // Start with SPE low: nothing happens, no collision flag.
    @(negedge apb_clk_in);
    spe_in = 1'b0;
    start_in = 1'b1;
    @(negedge apb_clk_in);
    start_in = 1'b0;
    check("nospe_busy", busy_out, 0);
    check("nospe_ss_n", ss_n_out, 1);
    repeat (3) @(negedge apb_clk_in);
    check("nospe_wcol", wcol_out, 0);
    check("nospe_spif", spif_out, 0);
    spe_in = 1'b1;

    // Abort mid-SHIFT (H=2, SHIFT spans cycles 2..33).
    hv = '{1'b0, 1'b0, 1'b0, 3'd1, 3'd0, 8'hC3, 1'b1, 8'h00, 8'hC3, 36};
    start_only(hv);
    repeat (10) @(negedge apb_clk_in);
    check("abort_pre_busy", busy_out, 1);
    spe_in = 1'b0;
    @(negedge apb_clk_in);
    check("abort_ss_n", ss_n_out, 1);
    check("abort_busy", busy_out, 0);
    check("abort_sck", sck_out, 0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_out) dcount++;
      @(negedge apb_clk_in);
    end
    check("abort_no_done", dcount, 0);
    check("abort_spif", spif_out, 0);
    check("abort_rx_kept", rx_data_out, 8'h33);
    spe_in = 1'b1;

    // Reset in the middle of a frame, then a normal frame afterwards.
    hv = '{1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 8'h96, 1'b1, 8'h00, 8'h96, 18};
    start_only(hv);
    repeat (8) @(negedge apb_clk_in);
    apb_rst_in = 1'b1;
    @(negedge apb_clk_in);
    check("mrst_sck", sck_out, 1);
    check("mrst_mosi", mosi_out, 0);
    check("mrst_ss_n", ss_n_out, 1);
    check("mrst_busy", busy_out, 0);
    check("mrst_rx", rx_data_out, 0);
    check("mrst_done", done_out, 0);
    check("mrst_spif", spif_out, 0);
    check("mrst_wcol", wcol_out, 0);
    apb_rst_in = 1'b0;
    hv = '{1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h3C, 1'b1, 8'h00, 8'h3C, 18};
    run_frame(hv, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
- SPI master transfer sequencer that sits behind the SPI register block.
- Takes the decoded CR1/CR2/baud fields and a TX byte, then generates SCK and SS_n and shifts one 8-bit frame on MOSI/MISO.
- Reports completion (SPIF) and write-collision (WCOL) back to the register block's status register.
- Mode bits CPOL, CPHA and LSBFE follow the register field meanings.

Parameters:
- DATA_WIDTH, 8, frame length in bits. Fixed at 8; the edge count is 2*DATA_WIDTH.
- DIV_WIDTH, 11, width of the half-period counter. Must hold (7+1)<<7 = 1024.

Ports:
- apb_clk_in  in  1  single clock for all logic.
- apb_rst_in  in  1  synchronous reset, active-high.
- spe_in  in  1  SPI enable (CR1.SPE).
- cpol_in  in  1  SCK idle level.
- cpha_in  in  1  clock phase.
- lsbfe_in  in  1  1 = LSB first.
- sppr_in  in  3  baud preselect.
- spr_in  in  3  baud select.
- start_in  in  1  one-cycle pulse: write to DR, start a frame.
- tx_data_in  in  8  byte to send; sampled with start_in.
- clr_flags_in  in  1  clears spif_out and wcol_out (SR read then DR access).
- miso_in  in  1  serial input.
- sck_out  out  1  serial clock.
- mosi_out  out  1  serial output.
- ss_n_out  out  1  slave select, active-low.
- busy_out  out  1  frame in progress.
- rx_data_out  out  8  last received byte.
- done_out  out  1  one-cycle pulse at frame end.
- spif_out  out  1  sticky transfer-complete flag.
- wcol_out  out  1  sticky write-collision flag.

Behaviour:
- Reset (apb_rst_in=1 at a clock edge), required output values:
  - sck_out = cpol_in (combinational while idle).
  - mosi_out = 0, ss_n_out = 1, busy_out = 0.
  - rx_data_out = 0, done_out = 0, spif_out = 0, wcol_out = 0.
  - FSM goes to IDLE and all counters clear.
  - Reset overrides any transfer in progress; no done_out is produced.
- Half period: H = (sppr_in+1) << spr_in clock cycles, range 1..1024. Baud fields are sampled on start and held for the whole frame.
- FSM states:
  - IDLE: start_in && spe_in → LEAD.
    - Latch tx_data_in, CPOL, CPHA, LSBFE and H.
    - busy_out=1 and ss_n_out=0 from the next cycle.
  - LEAD: lasts H cycles with SCK at CPOL.
    - If CPHA=0, the first bit is driven on mosi_out on LEAD entry.
    - → SHIFT.
  - SHIFT: 16 SCK edges, one every H cycles. The first edge occurs on the cycle SHIFT is entered.
    - Edges 1,3,…,15 are leading; edges 2,…,16 are trailing.
    - CPHA=0: sample miso_in on leading edges; drive the next bit on trailing edges 2..14.
    - CPHA=1: drive a bit on each leading edge; sample on trailing edges.
    - After edge 16 plus H cycles → TRAIL.
  - TRAIL: SCK=CPOL for H cycles, then ss_n_out=1 → DONE.
  - DONE: one cycle.
    - done_out=1, spif_out←1, rx_data_out updated, busy_out←0.
    - → IDLE.
- Bit order:
  - lsbfe=0: bit7 first; received bits shift in at bit0.
  - lsbfe=1: bit0 first; received bits shift in at bit7.
- Timing: with start_in accepted at edge T, done_out is high during cycle T+1+18H. A new start is accepted the cycle after done.
- start_in while busy: ignored and wcol_out←1. The in-flight frame is unaffected.
- start_in with spe_in=0: ignored, no flag.
- spe_in deasserted while busy:
  - Abort to IDLE on the next edge.
  - ss_n_out=1, sck=CPOL, busy=0.
  - No done, no SPIF, rx_data_out unchanged.
- clr_flags_in in the same cycle as a flag set: set wins.
- mosi_out holds its last bit between frames.

Test Plan:
- Mode 0, sppr=0, spr=0 (H=1), MISO looped to MOSI, start with 0xA5 at T → 8 rising SCK edges; done_out at T+19; rx_data_out=0xA5; spif_out=1.
- Mode 3, sppr=1, spr=1 (H=4), TX 0x3C, MISO driven by a slave model with 0xC3 → SCK idle high; SCK edges 4 cycles apart; MOSI changes on falling edges; rx=0xC3; done at T+73.
- lsbfe=1, mode 1, TX 0x01 → MOSI is 1 on the first bit only; a loopback rx reads 0x01.
- start_in pulsed at T+5 during a frame → wcol_out=1; first frame completes with the original data; clr_flags_in clears both flags.
- spe_in dropped mid-SHIFT → next cycle ss_n_out=1, busy=0, no done_out; spif_out stays 0.
- apb_rst_in asserted mid-frame → next cycle every output holds its listed reset value; no done_out; a following start works normally.
